alu_secuenciador: RTL and testbench

- Command-side initiator for the 8-bit combinational ALU (ops SUM, RES, PRO, DIV, MOD, AND, OR, XOR).
- Accepts operation commands over a valid/ready handshake and drives the ALU's Codigo_OP/Dato0/Dato1 from registers.
- Waits a fixed settle time, then captures Resultado and the flags, and returns them over a second valid/ready handshake.
- Screens divide/modulo by zero, which the ALU does not handle, and masks banderaA for operations that leave it stale.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_secuenciador_if.sv | 48 ++++
 rtl/alu_secuenciador.sv | 114 +++++++++++
 tb/tb_alu_secuenciador.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// small opcode classification helpers.
package alu_pkg;

  // ALU opcodes as understood by the combinational ALU.
  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_RES = 3'b001;
  localparam logic [2:0] OP_PRO = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Sequencer states: idle, waiting for the ALU to settle, delivering result.
  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    ESPERA  = 2'b01,
    ENTREGA = 2'b10
  } estado_t;

  // DIV and MOD are the only operations the ALU cannot do with Dato1 == 0.
  function automatic logic es_division(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Only SUM and RES refresh banderaA; for every other opcode it is stale.
  function automatic logic usa_bandera_a(input logic [2:0] op);
    return (op == OP_SUM) || (op == OP_RES);
  endfunction

endpackage

// File: rtl/alu_secuenciador_if.sv
// Bundle of the command handshake, the ALU drive/sample bus and the response
// handshake seen by the sequencer.
interface alu_secuenciador_if;

  // Command side
  logic        Cmd_Valido;
  logic        Cmd_Listo;
  logic [2:0]  Cmd_Codigo_OP;
  logic [7:0]  Cmd_Dato0;
  logic [7:0]  Cmd_Dato1;

  // ALU side
  logic [2:0]  Codigo_OP;
  logic [7:0]  Dato0;
  logic [7:0]  Dato1;
  logic [15:0] Resultado;
  logic        banderaA;
  logic        banderaB;

  // Response side
  logic        Rsp_Valido;
  logic        Rsp_Listo;
  logic [15:0] Rsp_Resultado;
  logic        Rsp_BanderaA;
  logic        Rsp_BanderaB;
  logic        Rsp_ErrorDiv;

  // The sequencer itself.
  modport slave (
    input  Cmd_Valido, Cmd_Codigo_OP, Cmd_Dato0, Cmd_Dato1,
    input  Resultado, banderaA, banderaB,
    input  Rsp_Listo,
    output Cmd_Listo,
    output Codigo_OP, Dato0, Dato1,
    output Rsp_Valido, Rsp_Resultado, Rsp_BanderaA, Rsp_BanderaB, Rsp_ErrorDiv
  );

  // The environment: command producer, ALU and response consumer.
  modport master (
    output Cmd_Valido, Cmd_Codigo_OP, Cmd_Dato0, Cmd_Dato1,
    output Resultado, banderaA, banderaB,
    output Rsp_Listo,
    input  Cmd_Listo,
    input  Codigo_OP, Dato0, Dato1,
    input  Rsp_Valido, Rsp_Resultado, Rsp_BanderaA, Rsp_BanderaB, Rsp_ErrorDiv
  );

endinterface

// File: rtl/alu_secuenciador.sv
// Command-side initiator for the 8-bit combinational ALU. Latches a command,
// drives the ALU from registers, waits CICLOS_ESPERA cycles for it to settle,
// then captures the result and hands it out over a valid/ready response.
// Divide/modulo by zero is answered immediately without consulting the ALU.
module alu_secuenciador
  import alu_pkg::*;
#(
  parameter int CICLOS_ESPERA = 1,   // legal 1..15
  parameter int ANCHO_CONT    = 16
) (
  input  logic                  Reloj,
  input  logic                  Reinicio_n,
  alu_secuenciador_if.slave     bus,
  output logic [ANCHO_CONT-1:0] Num_Ops
);

  // Counter reload value; the capture happens on the edge where it reads 0.
  localparam logic [3:0] CARGA_ESPERA = 4'(CICLOS_ESPERA - 1);

  estado_t               estado_reg;
  logic [3:0]            cont_reg;
  logic [2:0]            cod_op_reg;
  logic [7:0]            dato0_reg;
  logic [7:0]            dato1_reg;
  logic                  rsp_valido_reg;
  logic [15:0]           rsp_resultado_reg;
  logic                  rsp_bandera_a_reg;
  logic                  rsp_bandera_b_reg;
  logic                  rsp_error_div_reg;
  logic [ANCHO_CONT-1:0] num_ops_reg;

  // Sequencer FSM with all outputs registered; ALU operands only change on
  // command acceptance so they stay constant while the ALU settles.
  always_ff @(posedge Reloj or negedge Reinicio_n) begin
    if (!Reinicio_n) begin
      estado_reg        <= REPOSO;
      cont_reg          <= 4'd0;
      cod_op_reg        <= 3'b000;
      dato0_reg         <= 8'd0;
      dato1_reg         <= 8'd0;
      rsp_valido_reg    <= 1'b0;
      rsp_resultado_reg <= 16'd0;
      rsp_bandera_a_reg <= 1'b0;
      rsp_bandera_b_reg <= 1'b0;
      rsp_error_div_reg <= 1'b0;
      num_ops_reg       <= '0;
    end else begin
      case (estado_reg)
        REPOSO: begin
          if (bus.Cmd_Valido) begin
            cod_op_reg <= bus.Cmd_Codigo_OP;
            dato0_reg  <= bus.Cmd_Dato0;
            dato1_reg  <= bus.Cmd_Dato1;
            if (es_division(bus.Cmd_Codigo_OP) && (bus.Cmd_Dato1 == 8'd0)) begin
              // The ALU result would be meaningless: answer with an error now.
              rsp_resultado_reg <= 16'd0;
              rsp_bandera_a_reg <= 1'b0;
              rsp_bandera_b_reg <= 1'b0;
              rsp_error_div_reg <= 1'b1;
              rsp_valido_reg    <= 1'b1;
              estado_reg        <= ENTREGA;
            end else begin
              cont_reg   <= CARGA_ESPERA;
              estado_reg <= ESPERA;
            end
          end
        end

        ESPERA: begin
          if (cont_reg == 4'd0) begin
            rsp_resultado_reg <= bus.Resultado;
            rsp_bandera_a_reg <= bus.banderaA & usa_bandera_a(cod_op_reg);
            rsp_bandera_b_reg <= bus.banderaB;
            rsp_error_div_reg <= 1'b0;
            rsp_valido_reg    <= 1'b1;
            estado_reg        <= ENTREGA;
          end else begin
            cont_reg <= cont_reg - 4'd1;
          end
        end

        ENTREGA: begin
          // Response payload is left as-is after the handshake.
          if (bus.Rsp_Listo) begin
            rsp_valido_reg <= 1'b0;
            num_ops_reg    <= num_ops_reg + ANCHO_CONT'(1);
            estado_reg     <= REPOSO;
          end
        end

        default: begin
          estado_reg <= REPOSO;
        end
      endcase
    end
  end

  // Ready is a pure function of the state so a busy sequencer never
  // swallows a command.
  assign bus.Cmd_Listo     = (estado_reg == REPOSO);

  assign bus.Codigo_OP     = cod_op_reg;
  assign bus.Dato0         = dato0_reg;
  assign bus.Dato1         = dato1_reg;

  assign bus.Rsp_Valido    = rsp_valido_reg;
  assign bus.Rsp_Resultado = rsp_resultado_reg;
  assign bus.Rsp_BanderaA  = rsp_bandera_a_reg;
  assign bus.Rsp_BanderaB  = rsp_bandera_b_reg;
  assign bus.Rsp_ErrorDiv  = rsp_error_div_reg;

  assign Num_Ops           = num_ops_reg;

endmodule

// File: tb/tb_alu_secuenciador.sv
// Bench for alu_secuenciador: three instances (default, 4 settle cycles,
// 2-bit op counter) each wired to a behavioural ALU, sharing one stimulus
// bus steered by sel. Expected responses go through a scoreboard queue.
module tb_alu_secuenciador;
  import alu_pkg::*;

  localparam int NDUT = 3;
  localparam int CE [NDUT] = '{1, 4, 1};
  localparam int AW [NDUT] = '{16, 16, 2};

  typedef struct packed {
    logic [15:0] res;
    logic        a;
    logic        b;
    logic        err;
  } esperado_t;

  logic        Reloj = 1'b0;
  logic        rst_n;
  logic        cmd_valido;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_d0;
  logic [7:0]  cmd_d1;
  logic        rsp_listo;
  int          sel;

  logic        cmd_listo_v  [NDUT];
  logic [2:0]  cod_op_v     [NDUT];
  logic [7:0]  dato0_v      [NDUT];
  logic        rsp_valido_v [NDUT];
  logic [15:0] rsp_res_v    [NDUT];
  logic        rsp_a_v      [NDUT];
  logic        rsp_b_v      [NDUT];
  logic        rsp_err_v    [NDUT];
  logic [15:0] num_ops_v    [NDUT];

  esperado_t   sb [$];
  int          exp_num [NDUT];
  int          n_asserts = 0;
  int          n_fallos  = 0;

  always #5 Reloj = ~Reloj;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int AWI = AW[gi];
    alu_secuenciador_if bus ();
    logic [AWI-1:0] num_w;
    logic [15:0]    alu_r;
    logic           alu_c;
    logic           stale_a = 1'b0;

    assign bus.Cmd_Valido    = cmd_valido && (sel == gi);
    assign bus.Cmd_Codigo_OP = cmd_op;
    assign bus.Cmd_Dato0     = cmd_d0;
    assign bus.Cmd_Dato1     = cmd_d1;
    assign bus.Rsp_Listo     = rsp_listo && (sel == gi);

    // Behavioural ALU; banderaA only refreshes on SUM/RES, otherwise stale.
    always_comb begin
      alu_r = 16'd0;
      alu_c = 1'b0;
      case (bus.Codigo_OP)
        OP_SUM: begin
          alu_r = {8'd0, bus.Dato0} + {8'd0, bus.Dato1};
          alu_c = alu_r[8];
        end
        OP_RES: begin
          alu_r = {8'd0, bus.Dato0 - bus.Dato1};
          alu_c = (bus.Dato0 < bus.Dato1);
        end
        OP_PRO: alu_r = {8'd0, bus.Dato0} * {8'd0, bus.Dato1};
        OP_DIV: alu_r = (bus.Dato1 == 8'd0) ? 16'd0 : {8'd0, bus.Dato0 / bus.Dato1};
        OP_MOD: alu_r = (bus.Dato1 == 8'd0) ? 16'd0 : {8'd0, bus.Dato0 % bus.Dato1};
        OP_AND: alu_r = {8'd0, bus.Dato0 & bus.Dato1};
        OP_OR:  alu_r = {8'd0, bus.Dato0 | bus.Dato1};
        default: alu_r = {8'd0, bus.Dato0 ^ bus.Dato1};
      endcase
    end

    always @(posedge Reloj)
      if (usa_bandera_a(bus.Codigo_OP)) stale_a <= alu_c;

    assign bus.Resultado = alu_r;
    assign bus.banderaA  = usa_bandera_a(bus.Codigo_OP) ? alu_c : stale_a;
    assign bus.banderaB  = (alu_r == 16'd0);

    alu_secuenciador #(
      .CICLOS_ESPERA(CE[gi]),
      .ANCHO_CONT   (AWI)
    ) u_dut (
      .Reloj     (Reloj),
      .Reinicio_n(rst_n),
      .bus       (bus),
      .Num_Ops   (num_w)
    );

    assign cmd_listo_v[gi]  = bus.Cmd_Listo;
    assign cod_op_v[gi]     = bus.Codigo_OP;
    assign dato0_v[gi]      = bus.Dato0;
    assign rsp_valido_v[gi] = bus.Rsp_Valido;
    assign rsp_res_v[gi]    = bus.Rsp_Resultado;
    assign rsp_a_v[gi]      = bus.Rsp_BanderaA;
    assign rsp_b_v[gi]      = bus.Rsp_BanderaB;
    assign rsp_err_v[gi]    = bus.Rsp_ErrorDiv;
    assign num_ops_v[gi]    = 16'(num_w);
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_asserts++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: observed %0h, expected %0h (dut %0d, t=%0t)", tag, obs, esp, sel, $time);
    end
  endtask

  // Drive one command on the selected instance and follow it to delivery.
  // lat: edges after acceptance until Rsp_Valido; espera: backpressure cycles.
  task automatic enviar(input logic [2:0] op, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [15:0] e_res, input logic e_a, input logic e_b,
                        input logic e_err, input int lat, input int espera);
    int n;
    esperado_t e;
    n = 0;
    while (!cmd_listo_v[sel] && n < 50) begin
      @(negedge Reloj);
      n++;
    end
    comprobar("cmd_listo_idle", cmd_listo_v[sel], 1'b1);
    cmd_valido = 1'b1;
    cmd_op     = op;
    cmd_d0     = d0;
    cmd_d1     = d1;
    sb.push_back('{e_res, e_a, e_b, e_err});
    @(posedge Reloj);
    @(negedge Reloj);
    cmd_valido = 1'b0;
    cmd_op     = 3'($urandom);
    cmd_d0     = 8'($urandom);
    cmd_d1     = 8'($urandom);
    n = 0;
    while (!rsp_valido_v[sel] && n < 40) begin
      @(negedge Reloj);
      n++;
    end
    comprobar("latency", n, lat);
    comprobar("alu_op_held", cod_op_v[sel], op);
    comprobar("alu_dato0_held", dato0_v[sel], d0);
    for (int i = 0; i < espera; i++) begin
      // Offer a competing command while busy; it must be ignored.
      cmd_valido = 1'b1;
      cmd_op     = OP_OR;
      @(negedge Reloj);
      comprobar("bp_rsp_stable", rsp_res_v[sel], e_res);
      comprobar("bp_rsp_valido", rsp_valido_v[sel], 1'b1);
      comprobar("bp_cmd_listo", cmd_listo_v[sel], 1'b0);
      comprobar("bp_alu_op", cod_op_v[sel], op);
    end
    cmd_valido = 1'b0;
    if (sb.size() == 0) begin
      comprobar("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      comprobar("rsp_resultado", rsp_res_v[sel], e.res);
      comprobar("rsp_bandera_a", rsp_a_v[sel], e.a);
      comprobar("rsp_bandera_b", rsp_b_v[sel], e.b);
      comprobar("rsp_error_div", rsp_err_v[sel], e.err);
    end
    rsp_listo = 1'b1;
    @(posedge Reloj);
    @(negedge Reloj);
    rsp_listo = 1'b0;
    exp_num[sel] = (exp_num[sel] + 1) % (1 << AW[sel]);
    comprobar("rsp_valido_low", rsp_valido_v[sel], 1'b0);
    comprobar("num_ops", num_ops_v[sel], exp_num[sel]);
    comprobar("cmd_listo_after", cmd_listo_v[sel], 1'b1);
    $display("op %0d %0h,%0h on dut %0d -> res %0h A%0b B%0b E%0b ops %0d", op, d0, d1, sel,
             rsp_res_v[sel], rsp_a_v[sel], rsp_b_v[sel], rsp_err_v[sel], num_ops_v[sel]);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    rst_n      = 1'b0;
    cmd_valido = 1'b0;
    cmd_op     = 3'd0;
    cmd_d0     = 8'd0;
    cmd_d1     = 8'd0;
    rsp_listo  = 1'b0;
    sel        = 0;
    for (int i = 0; i < NDUT; i++) exp_num[i] = 0;
    repeat (3) @(negedge Reloj);

    comprobar("rst_cmd_listo", cmd_listo_v[0], 1'b1);
    comprobar("rst_rsp_valido", rsp_valido_v[0], 1'b0);
    comprobar("rst_rsp_res", rsp_res_v[0], 16'd0);
    comprobar("rst_alu_op", cod_op_v[0], 3'd0);
    comprobar("rst_num_ops", num_ops_v[0], 16'd0);
    rst_n = 1'b1;
    @(negedge Reloj);

    // Default instance: main operations.
    sel = 0;
    enviar(OP_SUM, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0, 1, 0);
    enviar(OP_PRO, 8'd15,  8'd17,  16'h00FF, 1'b0, 1'b0, 1'b0, 1, 0);
    enviar(OP_DIV, 8'd7,   8'd0,   16'h0000, 1'b0, 1'b0, 1'b1, 0, 0);
    enviar(OP_MOD, 8'd9,   8'd0,   16'h0000, 1'b0, 1'b0, 1'b1, 0, 0);
    enviar(OP_DIV, 8'd100, 8'd7,   16'd14,   1'b0, 1'b0, 1'b0, 1, 0);
    enviar(OP_XOR, 8'hAA,  8'h0F,  16'h00A5, 1'b0, 1'b0, 1'b0, 1, 5);
    enviar(OP_RES, 8'd5,   8'd9,   16'h00FC, 1'b1, 1'b0, 1'b0, 1, 0);

    // Four settle cycles.
    sel = 1;
    enviar(OP_AND, 8'hF0, 8'h0F, 16'h0000, 1'b0, 1'b1, 1'b0, 4, 0);

    // Same command, reset pulsed at edge N+2.
    cmd_valido = 1'b1;
    cmd_op     = OP_AND;
    cmd_d0     = 8'hF0;
    cmd_d1     = 8'h0F;
    @(posedge Reloj);
    @(negedge Reloj);
    cmd_valido = 1'b0;
    @(posedge Reloj);
    @(posedge Reloj);
    #1 rst_n = 1'b0;
    @(negedge Reloj);
    comprobar("mid_rst_rsp_valido", rsp_valido_v[1], 1'b0);
    comprobar("mid_rst_rsp_res", rsp_res_v[1], 16'd0);
    comprobar("mid_rst_alu_op", cod_op_v[1], 3'd0);
    comprobar("mid_rst_dato0", dato0_v[1], 8'd0);
    comprobar("mid_rst_num_ops", num_ops_v[1], 16'd0);
    comprobar("mid_rst_num_ops_dut0", num_ops_v[0], 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) exp_num[i] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Reloj);
      comprobar("post_rst_no_rsp", rsp_valido_v[1], 1'b0);
    end
    comprobar("post_rst_cmd_listo", cmd_listo_v[1], 1'b1);
    $display("reset at N+2 on dut 1 -> rsp_valido %0b ops %0d", rsp_valido_v[1], num_ops_v[1]);

    // 2-bit counter wraps: 1, 2, 3, 0, 1.
    sel = 2;
    for (int i = 0; i < 5; i++) begin
      enviar(OP_OR, 8'(i), 8'h10, {8'h00, 8'(i) | 8'h10}, 1'b0, 1'b0, 1'b0, 1, 0);
    end
    comprobar("wrap_final", num_ops_v[2], 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fallos);
    $finish;
  end

endmodule
